// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: issue/result bundle between the E-stage issue logic and the
// multiply/divide sequencing controller.
//   start, md_op, rs_val, rt_val : issue request from E stage
//   md_use_D                     : D-stage instruction touches the MD unit
//   hi, lo                       : architectural HI/LO registers
//   busy, done                   : operation in flight / last busy cycle
//   stall_md                     : stall request to the hazard unit
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_md;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_D,
    input  hi, lo, busy, done, stall_md
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_D,
    output hi, lo, busy, done, stall_md
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the multi-cycle multiply/divide unit
// and the HI/LO register pair. The result is computed in the issue cycle and
// held in pending registers; it is committed to HI/LO after a fixed latency.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   md      : mdu_ctrl_if slave (issue inputs, HI/LO, busy/done, stall_md)
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  mdu_ctrl_if.slave  md
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi, r_lo, r_p_hi, r_p_lo;
  logic               r_p_wr;

  logic               w_is_arith, w_issue, w_last, w_signed_div;
  logic [63:0]        w_ext_a, w_ext_b, w_prod;
  logic               w_a_neg, w_b_neg;
  logic [31:0]        w_abs_a, w_abs_b, w_uq, w_ur;
  logic [31:0]        w_res_hi, w_res_lo;
  logic               w_res_wr;

  assign w_is_arith   = (md.md_op >= 3'd1) && (md.md_op <= 3'd4);
  assign w_issue      = (r_state == IDLE) && md.start && w_is_arith;
  assign w_last       = (r_state == RUN) && (r_cnt == CNT_W'(1));
  assign w_signed_div = (md.md_op == 3'd3);

  // Multiply on sign/zero-extended operands; the low 64 bits of the product
  // are the correct signed or unsigned result.
  always_comb begin
    w_ext_a = (md.md_op == 3'd1) ? {{32{md.rs_val[31]}}, md.rs_val} : {32'b0, md.rs_val};
    w_ext_b = (md.md_op == 3'd1) ? {{32{md.rt_val[31]}}, md.rt_val} : {32'b0, md.rt_val};
    w_prod  = w_ext_a * w_ext_b;
  end

  // Signed divide via magnitudes so that 0x80000000 / -1 needs no special
  // case. A zero divisor is replaced by 1 only to keep the divider defined;
  // that result is never committed.
  always_comb begin
    w_a_neg = w_signed_div && md.rs_val[31];
    w_b_neg = w_signed_div && md.rt_val[31];
    w_abs_a = w_a_neg ? (32'd0 - md.rs_val) : md.rs_val;
    w_abs_b = (md.rt_val == '0) ? 32'd1 : (w_b_neg ? (32'd0 - md.rt_val) : md.rt_val);
    w_uq    = w_abs_a / w_abs_b;
    w_ur    = w_abs_a % w_abs_b;
  end

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    w_res_wr = 1'b0;
    if (md.md_op == 3'd1 || md.md_op == 3'd2) begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
      w_res_wr = 1'b1;
    end else begin
      w_res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
      w_res_hi = w_a_neg ? (32'd0 - w_ur) : w_ur;
      w_res_wr = (md.rt_val != '0);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next = RUN;
      RUN:     if (w_last)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counter, pending result and HI/LO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_p_wr <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_issue) begin
        r_p_hi <= w_res_hi;
        r_p_lo <= w_res_lo;
        r_p_wr <= w_res_wr;
        r_cnt  <= (md.md_op <= 3'd2) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (md.start && md.md_op == 3'd5) begin
        r_hi <= md.rs_val;
      end else if (md.start && md.md_op == 3'd6) begin
        r_lo <= md.rs_val;
      end
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last && r_p_wr) begin
        r_hi <= r_p_hi;
        r_lo <= r_p_lo;
      end
    end
  end

  // Outputs
  always_comb begin
    md.hi       = r_hi;
    md.lo       = r_lo;
    md.busy     = (r_state == RUN);
    md.done     = w_last;
    md.stall_md = md.md_use_D && ((r_state == RUN) || (md.start && w_is_arith));
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the multi-cycle multiply/divide unit and the HI/LO register pair in the five-stage pipeline. Accepts one MD operation per issue from the E stage, holds it for a fixed latency, commits the result to HI/LO, and raises a stall request to the hazard logic whenever the D-stage instruction needs the unit while it is occupied. The main stall unit ORs this request into its own stall output.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  E-stage instruction is an MD op; sampled each rising edge
- md_op  in  3  1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0/7 reserved
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse in the last busy cycle
- stall_md  out  1  stall request to the hazard unit

## Operation
- States: IDLE, RUN. Down-counter cnt, width sized for max(MULT_CYCLES, DIV_CYCLES); pending registers p_hi, p_lo; commit-enable flag p_wr.
- IDLE, start=1, md_op in {1..4}: compute the result from rs_val/rt_val in that cycle; latch it into p_hi/p_lo; load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
- mult: signed 64-bit product; multu: unsigned. HI = bits 63:32, LO = bits 31:0.
- div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend. 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: the operation still runs DIV_CYCLES cycles; p_wr=0, so HI/LO stay unchanged at commit.
- IDLE, start=1, md_op=5/6: hi (resp. lo) <= rs_val at this edge; no busy cycle; stays in IDLE.
- start with md_op 0/7: ignored.
- RUN: cnt decrements each cycle. In the cycle where cnt==1, done=1; at that edge HI/LO <= p_hi/p_lo (if p_wr), and the state returns to IDLE.
- start while in RUN: ignored; HI/LO and the pending result are untouched. The hazard logic prevents this in normal use; verification must still check it.
- stall_md = md_use_D & (busy | (start & md_op in {1..4})). This is combinational. Non-MD D-stage instructions never stall.
- Reset (reset_n=0 at an edge): state=IDLE, cnt=0, hi=0, lo=0, p_*=0, busy=0, done=0. The reset aborts any in-flight operation with no commit.

## Timing
- busy = (state==RUN), registered. done is decoded from registered state.
- A mult started in cycle t: busy=1 in cycles t+1..t+MULT_CYCLES; done=1 in cycle t+MULT_CYCLES; the new hi/lo is visible in cycle t+MULT_CYCLES+1, when busy=0.
- Division uses the same timing with DIV_CYCLES.
- mthi/mtlo in cycle t: the new value is visible in cycle t+1.
- A back-to-back MD op in D is stalled through the issue cycle and all busy cycles. It enters E in cycle t+N+1, so mfhi/mflo read committed values.
- Outputs after reset: hi=lo=0, busy=0, done=0. stall_md follows its inputs combinationally.

## Test plan
- mult rs=0xFFFFFFFE (-2), rt=3, start in cycle 0: busy in cycles 1-5, done in cycle 5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with multu give hi=0x2, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2: busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=2 gives lo=3, hi=1.
- mthi 0x12345678 then div rs=5, rt=0: hi=0x12345678 and lo unchanged after 10 busy cycles, and done still pulses.
- md_use_D=1 in the start cycle and during busy: stall_md=1 through cycle t+N and 0 in cycle t+N+1. With md_use_D=0, stall_md is 0 throughout.
- start mult in cycle 3 of a running div: the second op is ignored, and HI/LO hold the div result at the original commit time.
- Drive reset_n low in cycle 3 of a mult: busy=0, hi=lo=0 next cycle; no commit and no done pulse afterwards.
